pgm_sequencer: RTL and testbench
================================

PGM_SEQUENCER -- requirements
Module: pgm_sequencer

Interface
REQ-001 Parameter DEPTH, default 2048, SHALL set the device byte count (8755 EPROM); address width is 11.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000 (1 s at 50 MHz), SHALL set the host-byte inactivity timeout.
REQ-003 clk  in  1  sole clock, all logic on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  host byte; rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-006 tx_data  out  8  response byte; tx_valid  out  1  one-cycle send strobe; tx_busy  in  1  UART transmitter busy.
REQ-007 eng_start  out  1  one-cycle pulse launching one byte operation on the programming engine.
REQ-008 eng_mode  out  1  1 = program, 0 = read; eng_addr  out  11  byte address; eng_wdata  out  8  byte to program.
REQ-009 eng_done  in  1  one-cycle completion pulse; eng_rdata  in  8  byte read, valid with eng_done.
REQ-010 busy  out  1  high whenever state is not IDLE; err  out  1  sticky error flag, cleared by the next valid command.

Function
REQ-011 States SHALL be IDLE, LEN_LO, LEN_HI, WAIT_DATA, ENG_RUN, TX_BYTE, TX_END.
REQ-012 IDLE: on rx_valid, 'P' (0x50) = program, 'V' (0x56) = verify, 'B' (0x42) = blank check go to LEN_LO; any other byte sends NAK (0x15), sets err and stays in IDLE.
REQ-013 LEN_LO then LEN_HI SHALL capture a 12-bit length {LEN_HI[3:0], LEN_LO}; a length of 0 or above DEPTH ends the command with NAK.
REQ-014 The address SHALL start at 0 for every command, increment by 1 after each eng_done and never wrap; the command ends when the processed count equals the length.
REQ-015 Program: WAIT_DATA latches rx_data into eng_wdata; the next cycle ENG_RUN pulses eng_start with eng_mode=1; eng_done returns to WAIT_DATA, or to TX_END after the last byte.
REQ-016 Verify/blank: ENG_RUN pulses eng_start with eng_mode=0; eng_done latches eng_rdata and goes to TX_BYTE.
REQ-017 TX_BYTE: verify sends the read byte; blank check sends nothing for 0xFF and for any other value sends NAK, sets err and skips further bytes.
REQ-018 tx_valid SHALL be asserted only in a cycle where tx_busy is low, and at most once per byte.
REQ-019 TX_END SHALL send ACK (0x06) on success and then return to IDLE.
REQ-020 eng_start SHALL pulse exactly once per byte; the sequencer SHALL never issue a new eng_start before the matching eng_done.
REQ-021 Timeout: in LEN_LO, LEN_HI or WAIT_DATA, TIMEOUT_CYCLES cycles without rx_valid SHALL abort with NAK and set err; the timer reloads on every rx_valid.
REQ-022 An rx_valid in ENG_RUN, TX_BYTE or TX_END SHALL set an overrun flag; after the current eng_done the command ends with NAK, and an engine operation is never cut short.
REQ-023 eng_start and tx_valid SHALL never be asserted in the same cycle.

Reset
REQ-024 Assertion of rst_n low SHALL immediately force IDLE and drive all outputs to 0 (tx_data, eng_addr, eng_wdata included); counters, overrun and err clear.
REQ-025 A reset in mid-command SHALL discard the command, and no ACK/NAK SHALL be sent after release.

Configuration
REQ-026 With PGM_SEQ_CHECKSUM_EN defined, an 8-bit modulo-256 sum of all programmed or read bytes SHALL be sent immediately before ACK; without it, only ACK is sent and no checksum logic exists.

Structure
REQ-027 Package pgm_seq_pkg SHALL hold the state enum, the command codes, ACK/NAK and the address width constant.
REQ-028 The timeout SHALL be a sub-module seq_timer (inputs: reload, run; output: one-cycle expired).

Verification
REQ-029 'P', 0x03, 0x00, then bytes 0xAA,0x55,0x12 -> three eng_start pulses at addr 0,1,2 with matching eng_wdata, then ACK (with the macro: 0x11 before ACK).
REQ-030 'V', 0x02, 0x00 with the engine returning 0x3C,0xC3 -> tx bytes 0x3C,0xC3, ACK; tx_valid never asserted while tx_busy is high.
REQ-031 'B', 0x04, 0x00 with the engine returning 0xFF,0xFF,0x7F -> NAK after the third read, no fourth eng_start, err=1.
REQ-032 'P', 0x01, 0x00, then silence for TIMEOUT_CYCLES -> NAK, err=1, IDLE, no eng_start; 'Q' in IDLE -> NAK; length 0x801 -> NAK.
REQ-033 rst_n pulsed low during ENG_RUN -> outputs 0 immediately, no tx after release, and a subsequent 'V', 0x01, 0x00 completes normally.

Source files
------------

// File: rtl/pgm_seq_pkg.sv
// Shared constants for the 8755 EPROM programming sequencer: FSM states,
// host command codes, ACK/NAK bytes and the EPROM address width.
package pgm_seq_pkg;

    localparam int ADDR_W = 11;

    localparam logic [7:0] CMD_PROGRAM = 8'h50;
    localparam logic [7:0] CMD_VERIFY  = 8'h56;
    localparam logic [7:0] CMD_BLANK   = 8'h42;
    localparam logic [7:0] ACK         = 8'h06;
    localparam logic [7:0] NAK         = 8'h15;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LEN_LO    = 3'd1;
    localparam logic [2:0] ST_LEN_HI    = 3'd2;
    localparam logic [2:0] ST_WAIT_DATA = 3'd3;
    localparam logic [2:0] ST_ENG_RUN   = 3'd4;
    localparam logic [2:0] ST_TX_BYTE   = 3'd5;
    localparam logic [2:0] ST_TX_END    = 3'd6;

    typedef enum logic [1:0] {OP_PROGRAM, OP_VERIFY, OP_BLANK} op_e;

    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_PROGRAM) || (b == CMD_VERIFY) || (b == CMD_BLANK);
    endfunction

    function automatic op_e decode_op(input logic [7:0] b);
        op_e op;
        case (b)
            CMD_PROGRAM: op = OP_PROGRAM;
            CMD_VERIFY:  op = OP_VERIFY;
            default:     op = OP_BLANK;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Host inactivity timer: counts while run is high, restarts on reload or when
// idle, and emits a one-cycle expired pulse after CYCLES quiet cycles.
module seq_timer #(
    parameter int unsigned CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (reload || !run) begin
                count <= '0;
            end else if (count == W'(CYCLES - 1)) begin
                count   <= '0;
                expired <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pgm_sequencer.sv
// Host command sequencer driving a byte-wide EPROM programming engine.
// Define PGM_SEQ_CHECKSUM_EN to append a modulo-256 data checksum before ACK.
module pgm_sequencer
    import pgm_seq_pkg::*;
#(
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              eng_start,
    output logic              eng_mode,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    input  logic              eng_done,
    input  logic [7:0]        eng_rdata,
    output logic              busy,
    output logic              err
);

    logic [2:0]  state;
    op_e         op;
    logic [7:0]  len_lo;
    logic [11:0] length;
    logic [11:0] count;
    logic [7:0]  rdata;
    logic        issued;
    logic        overrun;
    logic        nak_pend;
`ifdef PGM_SEQ_CHECKSUM_EN
    logic [7:0]  sum;
    logic        sum_sent;
`endif

    logic        timer_expired;
    logic        abort;
    logic        tx_ok;
    logic        own_tx_ok;
    logic [11:0] len_new;
    logic [11:0] count_next;

    assign busy       = (state != ST_IDLE);
    assign len_new    = {rx_data[3:0], len_lo};
    assign count_next = count + 12'd1;
    // One idle cycle after each send lets the UART raise tx_busy before we look again.
    assign tx_ok      = !tx_busy && !tx_valid && (state != ST_ENG_RUN);
    assign own_tx_ok  = tx_ok && !nak_pend;

    seq_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (rx_valid),
        .run     ((state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_WAIT_DATA)),
        .expired (timer_expired)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        abort = 1'b0;
        case (state)
            ST_LEN_LO:    abort = timer_expired;
            ST_LEN_HI:    abort = timer_expired ||
                                  (rx_valid && ((len_new == 12'd0) || ({20'd0, len_new} > DEPTH)));
            ST_WAIT_DATA: abort = timer_expired;
            ST_ENG_RUN:   abort = issued && eng_done && (overrun || rx_valid);
            ST_TX_BYTE:   abort = rx_valid || ((op == OP_BLANK) && (rdata != 8'hFF));
            ST_TX_END:    abort = rx_valid;
            default:      abort = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op        <= OP_PROGRAM;
            len_lo    <= '0;
            length    <= '0;
            count     <= '0;
            rdata     <= '0;
            issued    <= 1'b0;
            overrun   <= 1'b0;
            nak_pend  <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            eng_start <= 1'b0;
            eng_mode  <= 1'b0;
            eng_addr  <= '0;
            eng_wdata <= '0;
            err       <= 1'b0;
`ifdef PGM_SEQ_CHECKSUM_EN
            sum       <= '0;
            sum_sent  <= 1'b0;
`endif
        end else begin
            eng_start <= 1'b0;
            tx_valid  <= 1'b0;
            if (nak_pend && tx_ok) begin
                tx_valid <= 1'b1;
                tx_data  <= NAK;
                nak_pend <= 1'b0;
            end

            if (abort) begin
                state    <= ST_IDLE;
                nak_pend <= 1'b1;
                err      <= 1'b1;
                overrun  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (rx_valid) begin
                        if (is_command(rx_data)) begin
                            op    <= decode_op(rx_data);
                            err   <= 1'b0;
                            state <= ST_LEN_LO;
                        end else begin
                            nak_pend <= 1'b1;
                            err      <= 1'b1;
                        end
                    end
                    ST_LEN_LO: if (rx_valid) begin
                        len_lo <= rx_data;
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: if (rx_valid) begin
                        length   <= len_new;
                        count    <= '0;
                        eng_addr <= '0;
                        issued   <= 1'b0;
                        overrun  <= 1'b0;
`ifdef PGM_SEQ_CHECKSUM_EN
                        sum      <= '0;
                        sum_sent <= 1'b0;
`endif
                        state    <= (op == OP_PROGRAM) ? ST_WAIT_DATA : ST_ENG_RUN;
                    end
                    ST_WAIT_DATA: if (rx_valid) begin
                        eng_wdata <= rx_data;
`ifdef PGM_SEQ_CHECKSUM_EN
                        sum       <= sum + rx_data;
`endif
                        issued    <= 1'b0;
                        state     <= ST_ENG_RUN;
                    end
                    ST_ENG_RUN: begin
                        if (rx_valid) overrun <= 1'b1;
                        if (!issued) begin
                            eng_start <= 1'b1;
                            eng_mode  <= (op == OP_PROGRAM);
                            issued    <= 1'b1;
                        end else if (eng_done) begin
                            issued <= 1'b0;
                            count  <= count_next;
                            // The address saturates at the top of the device instead of wrapping.
                            if (eng_addr != {ADDR_W{1'b1}}) eng_addr <= eng_addr + 1'b1;
                            if (op == OP_PROGRAM) begin
                                state <= (count_next == length) ? ST_TX_END : ST_WAIT_DATA;
                            end else begin
                                rdata <= eng_rdata;
`ifdef PGM_SEQ_CHECKSUM_EN
                                sum   <= sum + eng_rdata;
`endif
                                state <= ST_TX_BYTE;
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (op == OP_BLANK) begin
                            state <= (count == length) ? ST_TX_END : ST_ENG_RUN;
                        end else if (own_tx_ok) begin
                            tx_valid <= 1'b1;
                            tx_data  <= rdata;
                            state    <= (count == length) ? ST_TX_END : ST_ENG_RUN;
                        end
                    end
                    ST_TX_END: if (own_tx_ok) begin
                        tx_valid <= 1'b1;
`ifdef PGM_SEQ_CHECKSUM_EN
                        if (!sum_sent) begin
                            tx_data  <= sum;
                            sum_sent <= 1'b1;
                        end else begin
                            tx_data <= ACK;
                            state   <= ST_IDLE;
                        end
`else
                        tx_data <= ACK;
                        state   <= ST_IDLE;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pgm_sequencer.sv
// Directed scoreboard bench for pgm_sequencer with a behavioural engine and
// UART transmitter; honours PGM_SEQ_CHECKSUM_EN when building expectations.
module tb_pgm_sequencer;

    localparam int unsigned TMO = 200;
    localparam logic [7:0] B_ACK = 8'h06;
    localparam logic [7:0] B_NAK = 8'h15;
    localparam logic [31:0] NONE = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        mode;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        eng_start;
    logic        eng_mode;
    logic [10:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_done;
    logic [7:0]  eng_rdata;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int n_starts = 0;
    int n_tx     = 0;

    logic [7:0]  exp_tx[$];
    op_t         exp_op[$];
    logic [7:0]  rd_q[$];
    logic [31:0] mon_tx_want;
    logic [31:0] mon_op_want;
    int          eng_cnt;
    int          busy_cnt;

    pgm_sequencer #(.DEPTH(2048), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_busy   (tx_busy),
        .eng_start (eng_start),
        .eng_mode  (eng_mode),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Engine model: done three cycles after start, returning the next queued read byte.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt   <= 0;
            eng_done  <= 1'b0;
            eng_rdata <= 8'h00;
        end else begin
            eng_done <= 1'b0;
            if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    eng_done  <= 1'b1;
                    eng_rdata <= (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                end
            end else if (eng_start) begin
                eng_cnt <= 3;
            end
        end
    end

    // UART model: busy for four cycles after each accepted byte.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tx_valid) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tx_valid) begin
                n_tx++;
                if (exp_tx.size() != 0) mon_tx_want = {24'h0, exp_tx.pop_front()};
                else mon_tx_want = NONE;
                check("tx_byte", {24'h0, tx_data}, mon_tx_want);
                check("tx_while_busy", 32'(tx_busy), 32'd0);
                check("tx_with_start", 32'(eng_start), 32'd0);
            end
            if (eng_start) begin
                n_starts++;
                if (exp_op.size() != 0) begin
                    mon_op_want = {12'h0, exp_op[0].mode, exp_op[0].addr,
                                   exp_op[0].mode ? exp_op[0].wdata : 8'h00};
                    void'(exp_op.pop_front());
                end else begin
                    mon_op_want = NONE;
                end
                check("eng_op", {12'h0, eng_mode, eng_addr, eng_mode ? eng_wdata : 8'h00}, mon_op_want);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic push_op(input logic mode, input logic [10:0] addr, input logic [7:0] wdata);
        op_t o;
        o.mode  = mode;
        o.addr  = addr;
        o.wdata = wdata;
        exp_op.push_back(o);
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_op.size() != 0 || busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        check({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
        check({tag, "_op_left"}, 32'(exp_op.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check({tag, "_eng_mode"}, 32'(eng_mode), 32'd0);
        check({tag, "_eng_addr"}, 32'(eng_addr), 32'd0);
        check({tag, "_eng_wdata"}, 32'(eng_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int t0;
        rst_n    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Program three bytes.
        s0 = n_starts;
        push_op(1'b1, 11'd0, 8'hAA);
        push_op(1'b1, 11'd1, 8'h55);
        push_op(1'b1, 11'd2, 8'h12);
`ifdef PGM_SEQ_CHECKSUM_EN
        exp_tx.push_back(8'h11);
`endif
        exp_tx.push_back(B_ACK);
        send(8'h50, 2); send(8'h03, 2); send(8'h00, 2);
        send(8'hAA, 12); send(8'h55, 12); send(8'h12, 12);
        drain("prog", 500);
        check("prog_starts", 32'(n_starts - s0), 32'd3);
        check("prog_err", 32'(err), 32'd0);

        // Verify two bytes with UART back-pressure.
        push_op(1'b0, 11'd0, 8'h00);
        push_op(1'b0, 11'd1, 8'h00);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        exp_tx.push_back(8'h3C);
        exp_tx.push_back(8'hC3);
`ifdef PGM_SEQ_CHECKSUM_EN
        exp_tx.push_back(8'hFF);
`endif
        exp_tx.push_back(B_ACK);
        send(8'h56, 2); send(8'h02, 2); send(8'h00, 2);
        drain("verify", 500);
        check("verify_err", 32'(err), 32'd0);

        // Blank check fails on the third byte.
        s0 = n_starts;
        push_op(1'b0, 11'd0, 8'h00);
        push_op(1'b0, 11'd1, 8'h00);
        push_op(1'b0, 11'd2, 8'h00);
        rd_q.push_back(8'hFF);
        rd_q.push_back(8'hFF);
        rd_q.push_back(8'h7F);
        exp_tx.push_back(B_NAK);
        send(8'h42, 2); send(8'h04, 2); send(8'h00, 2);
        drain("blank", 500);
        check("blank_starts", 32'(n_starts - s0), 32'd3);
        check("blank_err", 32'(err), 32'd1);

        // Data timeout after a program header.
        s0 = n_starts;
        exp_tx.push_back(B_NAK);
        send(8'h50, 2);
        check("cmd_clears_err", 32'(err), 32'd0);
        send(8'h01, 2); send(8'h00, 2);
        drain("timeout", TMO + 100);
        check("timeout_starts", 32'(n_starts - s0), 32'd0);
        check("timeout_err", 32'(err), 32'd1);

        // Unknown command and out-of-range lengths.
        exp_tx.push_back(B_NAK);
        send(8'h51, 2);
        drain("bad_cmd", 100);
        check("bad_cmd_err", 32'(err), 32'd1);
        exp_tx.push_back(B_NAK);
        send(8'h56, 2); send(8'h01, 2); send(8'h08, 2);
        drain("len_801", 100);
        exp_tx.push_back(B_NAK);
        send(8'h42, 2); send(8'h00, 2); send(8'h00, 2);
        drain("len_0", 100);
        check("len_err", 32'(err), 32'd1);

        // Overrun while the engine runs: the read completes, then NAK.
        s0 = n_starts;
        push_op(1'b0, 11'd0, 8'h00);
        rd_q.push_back(8'h55);
        exp_tx.push_back(B_NAK);
        send(8'h56, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
        drain("overrun", 200);
        check("overrun_starts", 32'(n_starts - s0), 32'd1);

        // Reset in the middle of an engine operation.
        push_op(1'b0, 11'd0, 8'h00);
        rd_q.push_back(8'h99);
        send(8'h56, 2); send(8'h01, 2); send(8'h00, 0);
        @(posedge clk); #2;
        check("pre_reset_start", 32'(eng_start), 32'd1);
        rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        exp_op.delete();
        exp_tx.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        t0 = n_tx;
        repeat (40) @(posedge clk);
        check("post_reset_silent", 32'(n_tx - t0), 32'd0);

        // A fresh verify completes normally after the reset.
        push_op(1'b0, 11'd0, 8'h00);
        rd_q.push_back(8'hA5);
        exp_tx.push_back(8'hA5);
`ifdef PGM_SEQ_CHECKSUM_EN
        exp_tx.push_back(8'hA5);
`endif
        exp_tx.push_back(B_ACK);
        send(8'h56, 2); send(8'h01, 2); send(8'h00, 2);
        drain("after_reset", 300);
        check("after_reset_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
